// File: rtl/uart_cfg_controller_pkg.sv
// cfg_pkg: shared constants, FSM encoding and helpers for uart_cfg_controller.
package cfg_pkg;

   // Register map addresses
   localparam logic [3:0] CFG_FG_R  = 4'd0;
   localparam logic [3:0] CFG_FG_G  = 4'd1;
   localparam logic [3:0] CFG_FG_B  = 4'd2;
   localparam logic [3:0] CFG_BG_R  = 4'd3;
   localparam logic [3:0] CFG_BG_G  = 4'd4;
   localparam logic [3:0] CFG_BG_B  = 4'd5;
   localparam logic [3:0] CFG_MODE  = 4'd6;
   localparam logic [3:0] CFG_BLANK = 4'd7;
   localparam logic [3:0] CFG_BAUD  = 4'd8;

   // Reset colours
   localparam logic [11:0] RST_FG_COLOR = 12'hFFF;
   localparam logic [11:0] RST_BG_COLOR = 12'h000;

   // Settle counter width
   localparam int unsigned SETTLE_W = 8;

   // Sequencer state encoding
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WRITE    = 2'd1,
      ST_SETTLE   = 2'd2,
      ST_WAIT_LOW = 2'd3
   } cfg_state_e;

   // Replace one 4-bit channel of a {R,G,B} colour; idx 2=R, 1=G, 0=B.
   function automatic logic [11:0] set_nibble(input logic [11:0] color,
                                              input logic [1:0]  idx,
                                              input logic [3:0]  value);
      logic [11:0] result;
      case (idx)
         2'd2:    result = {value, color[7:0]};
         2'd1:    result = {color[11:8], value, color[3:0]};
         2'd0:    result = {color[11:4], value};
         default: result = color;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/uart_cfg_controller_settle_timer.sv
// settle_timer: loadable down-counter; done is high while the count is 1,
// i.e. during the last cycle of the settle window.
module settle_timer
   import cfg_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [SETTLE_W-1:0] load_val,
   output logic                done
);

   logic [SETTLE_W-1:0] count_q;
   logic [SETTLE_W-1:0] count_d;

   // Next count: load wins, otherwise count down and park at zero.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (count_q != {SETTLE_W{1'b0}}) begin
         count_d = count_q - {{(SETTLE_W-1){1'b0}}, 1'b1};
      end else begin
         count_d = count_q;
      end
   end

   // Counter register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count_q <= {SETTLE_W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign done = (count_q == {{(SETTLE_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/uart_cfg_controller.sv
// uart_cfg_controller: accepts decoded UART register writes, holds the VGA
// configuration set and sequences baud retunes (drop baud_ready, settle,
// re-raise). Optional build macro CFG_SHADOW_EN adds frame-synchronous
// shadow registers for addresses 0-7.
module uart_cfg_controller
   import cfg_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 32,
   parameter logic [2:0]  BAUD_RESET    = 3'b001,
   parameter logic [2:0]  BAUD_MAX      = 3'd4
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        valid,
   input  logic [3:0]  address,
   input  logic [3:0]  data,
   input  logic        frame_start,
   output logic        ack,
   output logic [11:0] fg_color,
   output logic [11:0] bg_color,
   output logic [3:0]  mode,
   output logic        blank,
   output logic [2:0]  baud,
   output logic        baud_ready,
   output logic        busy
);

   cfg_state_e  state_q, state_d;
   logic [3:0]  addr_q, addr_d;
   logic [3:0]  data_q, data_d;
   logic        ack_q, ack_d;
   logic        busy_q, busy_d;
   logic [2:0]  baud_q, baud_d;
   logic        baud_ready_q, baud_ready_d;
   logic        low_seen_q, low_seen_d;
   logic [11:0] fg_q, fg_d;
   logic [11:0] bg_q, bg_d;
   logic [3:0]  mode_q, mode_d;
   logic        blank_q, blank_d;

   logic        timer_load_s;
   logic        timer_done_s;

   // Register-file values after applying the write of the current cycle
   logic [11:0] tgt_fg_s, tgt_bg_s;
   logic [3:0]  tgt_mode_s;
   logic        tgt_blank_s;

`ifdef CFG_SHADOW_EN
   logic [11:0] sh_fg_q, sh_fg_d;
   logic [11:0] sh_bg_q, sh_bg_d;
   logic [3:0]  sh_mode_q, sh_mode_d;
   logic        sh_blank_q, sh_blank_d;
`else
   logic        unused_frame_start_s;
   assign unused_frame_start_s = frame_start;
`endif

   settle_timer u_settle_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load_s),
      .load_val (SETTLE_W'(SETTLE_CYCLES)),
      .done     (timer_done_s)
   );

   // Sequencer next state: capture, write/retune decision, settle, wait for valid low.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      data_d       = data_q;
      baud_d       = baud_q;
      baud_ready_d = baud_ready_q;
      low_seen_d   = low_seen_q;
      timer_load_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (valid) begin
               addr_d     = address;
               data_d     = data;
               low_seen_d = 1'b0;
               state_d    = ST_WRITE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WRITE: begin
            low_seen_d = ~valid;
            if ((addr_q == CFG_BAUD) && (data_q[2:0] <= BAUD_MAX) &&
                (data_q[2:0] != baud_q)) begin
               baud_d       = data_q[2:0];
               baud_ready_d = 1'b0;
               timer_load_s = 1'b1;
               state_d      = ST_SETTLE;
            end else begin
               state_d = ST_WAIT_LOW;
            end
         end
         ST_SETTLE: begin
            // The requester may release and re-raise valid while we settle;
            // remember the release so a fresh request is not mistaken for a held one.
            low_seen_d = low_seen_q | ~valid;
            if (timer_done_s) begin
               baud_ready_d = 1'b1;
               state_d      = ST_WAIT_LOW;
            end else begin
               state_d = ST_SETTLE;
            end
         end
         ST_WAIT_LOW: begin
            low_seen_d = low_seen_q | ~valid;
            if (!valid || low_seen_q) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT_LOW;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      ack_d  = (state_d == ST_WRITE);
      busy_d = (state_d != ST_IDLE);
   end

   // Register-file write and optional frame-synchronous commit.
   always_comb begin
`ifdef CFG_SHADOW_EN
      tgt_fg_s    = sh_fg_q;
      tgt_bg_s    = sh_bg_q;
      tgt_mode_s  = sh_mode_q;
      tgt_blank_s = sh_blank_q;
`else
      tgt_fg_s    = fg_q;
      tgt_bg_s    = bg_q;
      tgt_mode_s  = mode_q;
      tgt_blank_s = blank_q;
`endif
      if (state_q == ST_WRITE) begin
         case (addr_q)
            CFG_FG_R:  tgt_fg_s    = set_nibble(tgt_fg_s, 2'd2, data_q);
            CFG_FG_G:  tgt_fg_s    = set_nibble(tgt_fg_s, 2'd1, data_q);
            CFG_FG_B:  tgt_fg_s    = set_nibble(tgt_fg_s, 2'd0, data_q);
            CFG_BG_R:  tgt_bg_s    = set_nibble(tgt_bg_s, 2'd2, data_q);
            CFG_BG_G:  tgt_bg_s    = set_nibble(tgt_bg_s, 2'd1, data_q);
            CFG_BG_B:  tgt_bg_s    = set_nibble(tgt_bg_s, 2'd0, data_q);
            CFG_MODE:  tgt_mode_s  = data_q;
            CFG_BLANK: tgt_blank_s = data_q[0];
            default: begin
               // baud and reserved addresses leave the register file alone
            end
         endcase
      end else begin
         tgt_mode_s = tgt_mode_s;
      end
`ifdef CFG_SHADOW_EN
      sh_fg_d    = tgt_fg_s;
      sh_bg_d    = tgt_bg_s;
      sh_mode_d  = tgt_mode_s;
      sh_blank_d = tgt_blank_s;
      // A write landing in the frame_start cycle is part of this commit.
      if (frame_start) begin
         fg_d    = tgt_fg_s;
         bg_d    = tgt_bg_s;
         mode_d  = tgt_mode_s;
         blank_d = tgt_blank_s;
      end else begin
         fg_d    = fg_q;
         bg_d    = bg_q;
         mode_d  = mode_q;
         blank_d = blank_q;
      end
`else
      fg_d    = tgt_fg_s;
      bg_d    = tgt_bg_s;
      mode_d  = tgt_mode_s;
      blank_d = tgt_blank_s;
`endif
   end

   // All state and outputs registered; reset aborts any settle in progress.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         addr_q       <= 4'd0;
         data_q       <= 4'd0;
         ack_q        <= 1'b0;
         busy_q       <= 1'b0;
         baud_q       <= BAUD_RESET;
         baud_ready_q <= 1'b1;
         low_seen_q   <= 1'b0;
         fg_q         <= RST_FG_COLOR;
         bg_q         <= RST_BG_COLOR;
         mode_q       <= 4'd0;
         blank_q      <= 1'b0;
`ifdef CFG_SHADOW_EN
         sh_fg_q      <= RST_FG_COLOR;
         sh_bg_q      <= RST_BG_COLOR;
         sh_mode_q    <= 4'd0;
         sh_blank_q   <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         ack_q        <= ack_d;
         busy_q       <= busy_d;
         baud_q       <= baud_d;
         baud_ready_q <= baud_ready_d;
         low_seen_q   <= low_seen_d;
         fg_q         <= fg_d;
         bg_q         <= bg_d;
         mode_q       <= mode_d;
         blank_q      <= blank_d;
`ifdef CFG_SHADOW_EN
         sh_fg_q      <= sh_fg_d;
         sh_bg_q      <= sh_bg_d;
         sh_mode_q    <= sh_mode_d;
         sh_blank_q   <= sh_blank_d;
`endif
      end
   end

   assign ack        = ack_q;
   assign busy       = busy_q;
   assign baud       = baud_q;
   assign baud_ready = baud_ready_q;
   assign fg_color   = fg_q;
   assign bg_color   = bg_q;
   assign mode       = mode_q;
   assign blank      = blank_q;

endmodule
